// File: rtl/video_pattern_gen_pkg.sv
// Shared mode encodings and bar palette for the test-pattern source.
package video_pkg;

  typedef enum logic [2:0] {
    MODE_BARS    = 3'd0,
    MODE_RAMP    = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_SOLID   = 3'd3,
    MODE_BOX     = 3'd4
  } mode_e;

  localparam logic [2:0] PAL_WHITE   = 3'd0;
  localparam logic [2:0] PAL_YELLOW  = 3'd1;
  localparam logic [2:0] PAL_CYAN    = 3'd2;
  localparam logic [2:0] PAL_GREEN   = 3'd3;
  localparam logic [2:0] PAL_MAGENTA = 3'd4;
  localparam logic [2:0] PAL_RED     = 3'd5;
  localparam logic [2:0] PAL_BLUE    = 3'd6;
  localparam logic [2:0] PAL_BLACK   = 3'd7;

  // Colours as {R,G,B} on/off masks, expanded to full scale by the user.
  localparam logic [2:0] RGB_WHITE   = 3'b111;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_BLACK   = 3'b000;

  function automatic logic [2:0] barMask(input logic [2:0] idx);
    case (idx)
      PAL_WHITE:   return RGB_WHITE;
      PAL_YELLOW:  return RGB_YELLOW;
      PAL_CYAN:    return RGB_CYAN;
      PAL_GREEN:   return RGB_GREEN;
      PAL_MAGENTA: return RGB_MAGENTA;
      PAL_RED:     return RGB_RED;
      PAL_BLUE:    return RGB_BLUE;
      default:     return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen_bounce_axis.sv
// One axis of the bouncing box: steps by one per enable, reversing at 0 and RANGE-SIZE.
module bounce_axis #(
  parameter int RANGE    = 640,
  parameter int SIZE     = 32,
  parameter int POS_BITS = 10
) (
  input  logic                pixelClock,
  input  logic                resetN,
  input  logic                step,
  output logic [POS_BITS-1:0] pos,
  output logic                dirUp
);

  localparam logic [POS_BITS-1:0] MAX_POS = POS_BITS'(RANGE - SIZE);

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      pos   <= '0;
      dirUp <= 1'b1;
    end else if (step) begin
      if (dirUp && pos == MAX_POS) begin
        dirUp <= 1'b0;
        pos   <= pos - 1'b1;
      end else if (!dirUp && pos == '0) begin
        dirUp <= 1'b1;
        pos   <= pos + 1'b1;
      end else if (dirUp) begin
        pos <= pos + 1'b1;
      end else begin
        pos <= pos - 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Multi-mode HDMI test-pattern source with one registered cycle of latency.
// Optional 1-pixel white border: define VIDEO_PATTERN_BORDER_EN.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_BITS       = 10,
  parameter int V_BITS       = 10,
  parameter int COLOR_BITS   = 8,
  parameter int NUM_BARS     = 7,
  parameter int CHECKER_LOG2 = 5,
  parameter int BOX_SIZE     = 32
) (
  input  logic                    pixelClock,
  input  logic                    resetN,
  input  logic [2:0]              modeSelect,
  input  logic [3*COLOR_BITS-1:0] solidColor,
  input  logic                    inActiveDisplay,
  input  logic [H_BITS-1:0]       hPosCounter,
  input  logic [V_BITS-1:0]       vPosCounter,
  output logic [COLOR_BITS-1:0]   redByte,
  output logic [COLOR_BITS-1:0]   greenByte,
  output logic [COLOR_BITS-1:0]   blueByte,
  output logic                    frameDone,
  output logic [2:0]              activeMode
);

  localparam int BAR_WIDTH = H_ACTIVE / NUM_BARS;
  localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_ACTIVE - 1);
  localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_ACTIVE - 1);
  localparam logic [H_BITS-1:0] BAR_LAST = H_BITS'(BAR_WIDTH - 1);
  localparam logic [2:0]        IDX_MAX  = 3'(NUM_BARS - 1);
  localparam logic [H_BITS:0]   BOX_H    = (H_BITS+1)'(BOX_SIZE);
  localparam logic [V_BITS:0]   BOX_V    = (V_BITS+1)'(BOX_SIZE);

  logic                    frameEnd;
  logic                    boxStep;
  logic [H_BITS-1:0]       barCnt, curCnt;
  logic [2:0]              barIdx, curIdx;
  logic [H_BITS-1:0]       boxX;
  logic [V_BITS-1:0]       boxY;
  logic                    dirX, dirY;
  logic                    inBox;
  logic [COLOR_BITS-1:0]   ramp;
  logic [2:0]              barRgb;
  logic [3*COLOR_BITS-1:0] pixRgb;

  assign frameEnd = inActiveDisplay && hPosCounter == H_LAST && vPosCounter == V_LAST;
  assign boxStep  = frameEnd && activeMode == MODE_BOX;

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      frameDone  <= 1'b0;
      activeMode <= '0;
    end else begin
      frameDone <= frameEnd;
      if (frameEnd) activeMode <= modeSelect;
    end
  end

  // Bar tracking without a divider: hPos==0 forces the counters to zero in the
  // same cycle so the first pixel of every line renders from bar 0.
  assign curCnt = (hPosCounter == '0) ? '0 : barCnt;
  assign curIdx = (hPosCounter == '0) ? '0 : barIdx;

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      barCnt <= '0;
      barIdx <= '0;
    end else if (inActiveDisplay) begin
      if (curCnt == BAR_LAST) begin
        barCnt <= '0;
        barIdx <= (curIdx == IDX_MAX) ? curIdx : curIdx + 3'd1;
      end else begin
        barCnt <= curCnt + 1'b1;
        barIdx <= curIdx;
      end
    end
  end

  bounce_axis #(.RANGE(H_ACTIVE), .SIZE(BOX_SIZE), .POS_BITS(H_BITS)) uAxisX (
    .pixelClock(pixelClock),
    .resetN    (resetN),
    .step      (boxStep),
    .pos       (boxX),
    .dirUp     (dirX)
  );

  bounce_axis #(.RANGE(V_ACTIVE), .SIZE(BOX_SIZE), .POS_BITS(V_BITS)) uAxisY (
    .pixelClock(pixelClock),
    .resetN    (resetN),
    .step      (boxStep),
    .pos       (boxY),
    .dirUp     (dirY)
  );

  assign inBox = ({1'b0, hPosCounter} >= {1'b0, boxX}) &&
                 ({1'b0, hPosCounter} <  {1'b0, boxX} + BOX_H) &&
                 ({1'b0, vPosCounter} >= {1'b0, boxY}) &&
                 ({1'b0, vPosCounter} <  {1'b0, boxY} + BOX_V);

  generate
    if (H_BITS >= COLOR_BITS) begin : gRampSlice
      always_comb ramp = hPosCounter[COLOR_BITS-1:0];
    end else begin : gRampExtend
      always_comb ramp = {{(COLOR_BITS-H_BITS){1'b0}}, hPosCounter};
    end
  endgenerate

  assign barRgb = barMask(curIdx);

  always_comb begin
    pixRgb = '0;
    case (activeMode)
      MODE_BARS:    pixRgb = {{COLOR_BITS{barRgb[2]}}, {COLOR_BITS{barRgb[1]}},
                              {COLOR_BITS{barRgb[0]}}};
      MODE_RAMP:    pixRgb = {ramp, ramp, ramp};
      MODE_CHECKER: pixRgb = (hPosCounter[CHECKER_LOG2] ^ vPosCounter[CHECKER_LOG2]) ? '1 : '0;
      MODE_SOLID:   pixRgb = solidColor;
      MODE_BOX:     pixRgb = inBox ? '1 : {{(2*COLOR_BITS){1'b0}}, {COLOR_BITS{1'b1}}};
      default:      pixRgb = '0;
    endcase
`ifdef VIDEO_PATTERN_BORDER_EN
    if (activeMode <= 3'd4 &&
        (hPosCounter == '0 || hPosCounter == H_LAST ||
         vPosCounter == '0 || vPosCounter == V_LAST))
      pixRgb = '1;
`else
`endif
    if (!inActiveDisplay) pixRgb = '0;
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      redByte   <= '0;
      greenByte <= '0;
      blueByte  <= '0;
    end else begin
      {redByte, greenByte, blueByte} <= pixRgb;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed self-checking bench for video_pattern_gen at default parameters.
module tb_video_pattern_gen;

  logic        pixelClock = 1'b0;
  logic        resetN;
  logic [2:0]  modeSelect;
  logic [23:0] solidColor;
  logic        inActiveDisplay;
  logic [9:0]  hPosCounter;
  logic [9:0]  vPosCounter;
  logic [7:0]  redByte, greenByte, blueByte;
  logic        frameDone;
  logic [2:0]  activeMode;
  logic [23:0] rgb;

  int nChecks = 0;
  int nFails  = 0;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] BLACK   = 24'h000000;

  video_pattern_gen dut (
    .pixelClock     (pixelClock),
    .resetN         (resetN),
    .modeSelect     (modeSelect),
    .solidColor     (solidColor),
    .inActiveDisplay(inActiveDisplay),
    .hPosCounter    (hPosCounter),
    .vPosCounter    (vPosCounter),
    .redByte        (redByte),
    .greenByte      (greenByte),
    .blueByte       (blueByte),
    .frameDone      (frameDone),
    .activeMode     (activeMode)
  );

  always #5 pixelClock = ~pixelClock;
  assign rgb = {redByte, greenByte, blueByte};

  // Apply one pixel at the falling edge, then sample just after the rising edge.
  task automatic px(input int h, input int v, input logic en);
    @(negedge pixelClock);
    hPosCounter     = 10'(h);
    vPosCounter     = 10'(v);
    inActiveDisplay = en;
    @(posedge pixelClock);
    #1;
  endtask

  task automatic pixCheck(input int h, input int v, input logic [23:0] exp, input string name);
    px(h, v, 1'b1);
    nChecks++;
    if (rgb !== exp) begin
      nFails++;
      $display("FAIL %s (h=%0d v=%0d): got %06h expected %06h", name, h, v, rgb, exp);
    end
  endtask

  task automatic frameEndPulse();
    px(639, 479, 1'b1);
  endtask

  task automatic test_reset();
    resetN = 1'b0; modeSelect = 3'd0; solidColor = '0;
    inActiveDisplay = 1'b1; hPosCounter = 10'd100; vPosCounter = 10'd5;
    repeat (3) @(posedge pixelClock);
    #1;
    nChecks++;
    if (rgb !== BLACK || activeMode !== 3'd0 || frameDone !== 1'b0) begin
      nFails++;
      $display("FAIL reset_state: rgb=%06h mode=%0d fd=%b expected 000000/0/0", rgb, activeMode, frameDone);
    end
    @(negedge pixelClock);
    resetN = 1'b1;
    pixCheck(0, 5, WHITE, "reset_first_pixel");
  endtask

  task automatic test_bars();
    logic [23:0] exp;
    for (int h = 0; h < 640; h++) begin
      if      (h < 91)  exp = WHITE;
      else if (h < 182) exp = YELLOW;
      else if (h < 273) exp = CYAN;
      else if (h < 364) exp = GREEN;
      else if (h < 455) exp = MAGENTA;
      else if (h < 546) exp = RED;
      else              exp = BLUE;
      pixCheck(h, 10, exp, "bars_sweep");
    end
    px(0, 11, 1'b0);
    nChecks++;
    if (rgb !== BLACK) begin
      nFails++;
      $display("FAIL bars_blank: got %06h expected 000000", rgb);
    end
  endtask

  task automatic test_mode_change();
    modeSelect = 3'd2;
    pixCheck(0, 100, WHITE, "midframe_still_bars");
    pixCheck(1, 100, WHITE, "midframe_still_bars");
    nChecks++;
    if (activeMode !== 3'd0) begin
      nFails++;
      $display("FAIL midframe_mode: got %0d expected 0", activeMode);
    end
    frameEndPulse();
    nChecks++;
    if (frameDone !== 1'b1 || activeMode !== 3'd2) begin
      nFails++;
      $display("FAIL frame_end: fd=%b mode=%0d expected 1/2", frameDone, activeMode);
    end
    pixCheck(32, 0, WHITE, "checker_32_0");
    nChecks++;
    if (frameDone !== 1'b0) begin
      nFails++;
      $display("FAIL frame_done_width: got %b expected 0", frameDone);
    end
    pixCheck(32, 32, BLACK, "checker_32_32");
    pixCheck(5, 40, WHITE, "checker_5_40");
    pixCheck(70, 70, BLACK, "checker_70_70");
  endtask

  task automatic test_ramp();
    modeSelect = 3'd1;
    frameEndPulse();
`ifdef VIDEO_PATTERN_BORDER_EN
    pixCheck(0, 5, WHITE, "ramp_border_left");
    pixCheck(639, 5, WHITE, "ramp_border_right");
`else
    pixCheck(0, 5, BLACK, "ramp_0");
`endif
    pixCheck(1, 5, 24'h010101, "ramp_1");
    pixCheck(255, 5, 24'hFFFFFF, "ramp_255");
    pixCheck(256, 5, 24'h000000, "ramp_wrap");
    pixCheck(300, 5, 24'h2C2C2C, "ramp_300");
  endtask

  task automatic test_solid();
    modeSelect = 3'd3;
    solidColor = 24'h123456;
    frameEndPulse();
    pixCheck(10, 10, 24'h123456, "solid_a");
    pixCheck(400, 300, 24'h123456, "solid_b");
    px(400, 300, 1'b0);
    nChecks++;
    if (rgb !== BLACK) begin
      nFails++;
      $display("FAIL solid_blank: got %06h expected 000000", rgb);
    end
  endtask

  task automatic test_unused_mode();
    modeSelect = 3'd6;
    frameEndPulse();
    pixCheck(10, 10, BLACK, "mode6_black");
  endtask

  task automatic test_box();
    modeSelect = 3'd4;
    frameEndPulse();
    pixCheck(0, 0, WHITE, "box0_origin");
    pixCheck(31, 31, WHITE, "box0_corner");
    pixCheck(32, 0, BLUE, "box0_right");
    pixCheck(0, 32, BLUE, "box0_below");
    repeat (448) frameEndPulse();
    pixCheck(448, 448, WHITE, "box448_origin");
    pixCheck(479, 479, WHITE, "box448_corner");
    pixCheck(447, 448, BLUE, "box448_left");
    frameEndPulse();
    pixCheck(449, 447, WHITE, "box449_origin");
    pixCheck(449, 479, BLUE, "box449_yflip");
    repeat (159) frameEndPulse();
    pixCheck(608, 288, WHITE, "box608_origin");
    pixCheck(639, 319, WHITE, "box608_corner");
    pixCheck(607, 288, BLUE, "box608_left");
    pixCheck(608, 287, BLUE, "box608_above");
    frameEndPulse();
    pixCheck(607, 287, WHITE, "box609_origin");
    pixCheck(639, 287, BLUE, "box609_xflip");
  endtask

  task automatic test_reset_midframe();
    pixCheck(607, 287, WHITE, "pre_reset_pixel");
    @(negedge pixelClock);
    #2;
    resetN = 1'b0;
    #1;
    nChecks++;
    if (rgb !== BLACK || activeMode !== 3'd0) begin
      nFails++;
      $display("FAIL midframe_reset: rgb=%06h mode=%0d expected 000000/0", rgb, activeMode);
    end
    @(negedge pixelClock);
    resetN = 1'b1;
    pixCheck(0, 0, WHITE, "post_reset_bars");
  endtask

  initial begin
    test_reset();
    test_bars();
    test_mode_change();
    test_ramp();
    test_solid();
    test_unused_mode();
    test_box();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
